lives_controller: RTL and testbench
===================================

Name: lives_controller

Overview:
- Sequences the player's life count for a fruit-slicing game.
- Consumes one-cycle event pulses from the game logic: missed fruit, bomb hit, bonus fruit and start.
- Maintains the 2-bit lives value, enforces a post-hit invulnerability window and flags game over.
- Its lives output drives the board's lives seven-segment decoder directly; game_over/playing feed the top-level game FSM.

Parameters:
START_LIVES, 3, lives loaded on start (1..3; values outside this range are illegal).
INV_CYCLES, 25000000, invulnerability length in clock cycles after losing a life (0.5 s at 50 MHz); minimum 1.
CNT_W, $clog2(INV_CYCLES+1), width of the invulnerability counter; derived, do not override.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins or restarts a game.
miss  input  1  one-cycle pulse; fruit fell off screen.
bomb  input  1  one-cycle pulse; player sliced a bomb.
bonus  input  1  one-cycle pulse; player sliced a bonus fruit.
lives  output  2  current lives, 0..3.
playing  output  1  high in PLAY or HIT.
invuln  output  1  high in HIT; used for sprite blinking.
life_lost  output  1  one-cycle pulse on each decrement.
game_over  output  1  high in OVER.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, lives=0, counter=0, all flag outputs 0.
- All outputs are registered. An event sampled on edge N is visible after edge N; latency is 1 cycle.
- State IDLE:
  - start -> PLAY, lives=START_LIVES.
  - All other inputs ignored.
- State PLAY:
  - bomb has priority over miss. If lives==1, -> OVER and lives=0.
  - Otherwise lives-=1, life_lost=1, counter=INV_CYCLES-1, -> HIT.
  - A miss that reaches lives==0 goes to OVER, with life_lost=1.
  - bonus with no miss/bomb in the same cycle: lives=min(lives+1,3). Saturates; never wraps.
  - bonus in the same cycle as miss/bomb is dropped.
  - start ignored.
- State HIT:
  - miss and bomb ignored.
  - bonus is still applied (saturating).
  - counter decrements each cycle; at counter==0 -> PLAY on the next edge.
  - The HIT duration is therefore exactly INV_CYCLES cycles.
  - start ignored.
- State OVER:
  - lives held at 0, game_over=1.
  - start -> PLAY with lives=START_LIVES; game_over clears on the same edge.
  - miss, bomb and bonus ignored.
- life_lost is high for exactly the cycle after the decrementing edge.
- lives never underflows below 0 and never exceeds 3.
- Reset asserted mid-HIT or mid-game returns immediately to IDLE, lives=0. No pending events survive.
- No simultaneous-pulse assumption on inputs: any combination resolves by the priority rules above.

Optional Feature:
BONUS_LIFE_EN
- Defined: bonus behaves as described above.
- Undefined: the bonus port is present but ignored; lives only ever decrease within a game.

Decomposition:
- Package lives_pkg:
  - state enum {IDLE, PLAY, HIT, OVER}
  - LIVES_W=2
  - MAX_LIVES=3
- Sub-module inv_timer:
  - Loadable down-counter with load, load_value and a done flag.
  - Instantiated once, parameterised by CNT_W.
- The main module holds the FSM and the lives register.

Test Plan (sim with INV_CYCLES=4, START_LIVES=3, BONUS_LIFE_EN defined):
1. Reset, then start -> next cycle lives=3, playing=1, game_over=0.
2. miss; then miss on each of the following 3 cycles:
   - lives=2, life_lost pulses once, invuln=1 for exactly 4 cycles.
   - The extra misses are ignored; lives stays 2.
3. From lives=1 in PLAY, bomb -> lives=0, game_over=1, playing=0. A later miss changes nothing.
4. lives=3 in PLAY, bonus -> lives stays 3. Then lives=2, bonus -> lives=3.
   - miss+bonus in the same cycle -> lives decrements, bonus dropped.
5. bomb+miss in the same cycle with lives=3 -> lives=2 (one decrement only), enters HIT.
6. Mid-HIT, resetn low for 1 cycle -> IDLE, lives=0, invuln=0. start -> lives=3. Also from OVER, start -> lives=3, game_over=0.

Source files
------------

// File: rtl/lives_controller_pkg.sv
// lives_pkg: shared state encoding and lives limits for the lives controller.
package lives_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
    localparam int LIVES_W = 2;
    localparam int MAX_LIVES = 3;
endpackage

// File: rtl/lives_controller_if.sv
// lives_controller_if: game-event pulses in, lives/status outputs back.
interface lives_controller_if;
    import lives_pkg::*;
    logic start;
    logic miss;
    logic bomb;
    logic bonus;
    logic [LIVES_W-1:0] lives;
    logic playing;
    logic invuln;
    logic life_lost;
    logic game_over;
    modport master(output start, miss, bomb, bonus,
                   input lives, playing, invuln, life_lost, game_over);
    modport slave(input start, miss, bomb, bonus,
                  output lives, playing, invuln, life_lost, game_over);
endinterface

// File: rtl/lives_controller_inv_timer.sv
// inv_timer: loadable down-counter that stops at zero and flags done there.
module inv_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);
    logic [CNT_W-1:0] count;
    assign done = count == '0;
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) count <= '0;
        else if (load) count <= load_value;
        else if (!done) count <= count - CNT_W'(1);
endmodule

// File: rtl/lives_controller.sv
// lives_controller: life-count FSM with post-hit invulnerability window.
// Define BONUS_LIFE_EN to let bonus pulses add a life; otherwise bonus is ignored.
module lives_controller
    import lives_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int INV_CYCLES  = 25000000
) (
    input  logic               clock,
    input  logic               resetn,
    lives_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(INV_CYCLES + 1);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_HIT  = HIT;
    localparam logic [1:0] ST_OVER = OVER;
`ifdef BONUS_LIFE_EN
    localparam logic BONUS_EN = 1'b1;
`else
    localparam logic BONUS_EN = 1'b0;
`endif
    logic [1:0] state, state_n;
    logic [LIVES_W-1:0] lives_q, lives_n, lives_inc;
    logic lost_n, load, done, hit_ev, bonus_ev;
    assign hit_ev    = bus.miss | bus.bomb;
    assign bonus_ev  = bus.bonus & BONUS_EN;
    assign lives_inc = (lives_q == LIVES_W'(MAX_LIVES)) ? lives_q : lives_q + LIVES_W'(1);
    assign bus.lives = lives_q;
    inv_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .load_value (CNT_W'(INV_CYCLES - 1)),
        .done       (done)
    );
    always_comb begin
        state_n = state;
        lives_n = lives_q;
        lost_n  = 1'b0;
        load    = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) begin
                state_n = ST_PLAY;
                lives_n = LIVES_W'(START_LIVES);
            end
            ST_PLAY: if (hit_ev) begin
                lost_n  = 1'b1;
                lives_n = lives_q - LIVES_W'(1);
                load    = lives_q != LIVES_W'(1);
                state_n = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_HIT;
            end else if (bonus_ev) lives_n = lives_inc;
            ST_HIT: begin
                lives_n = bonus_ev ? lives_inc : lives_q;
                state_n = done ? ST_PLAY : ST_HIT;
            end
            default: begin
                lives_n = bus.start ? LIVES_W'(START_LIVES) : '0;
                state_n = bus.start ? ST_PLAY : ST_OVER;
            end
        endcase
    end
    // Flags decode the next state so they are registered alongside it.
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state         <= ST_IDLE;
            lives_q       <= '0;
            bus.life_lost <= 1'b0;
            bus.playing   <= 1'b0;
            bus.invuln    <= 1'b0;
            bus.game_over <= 1'b0;
        end else begin
            state         <= state_n;
            lives_q       <= lives_n;
            bus.life_lost <= lost_n;
            bus.playing   <= state_n == ST_PLAY || state_n == ST_HIT;
            bus.invuln    <= state_n == ST_HIT;
            bus.game_over <= state_n == ST_OVER;
        end
endmodule

// File: tb/tb_lives_controller.sv
// tb_lives_controller: directed checks of the lives FSM with INV_CYCLES=4.
module tb_lives_controller;
`ifdef BONUS_LIFE_EN
    localparam logic BEN = 1'b1;
`else
    localparam logic BEN = 1'b0;
`endif
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_lives;
    logic [5:0] obs;
    lives_controller_if bus();
    lives_controller #(.START_LIVES(3), .INV_CYCLES(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );
    always #5 clock = ~clock;
    assign obs = {bus.lives, bus.playing, bus.invuln, bus.life_lost, bus.game_over};
    // ev = {start, miss, bomb, bonus}; outputs are sampled 1 time unit after the edge
    task automatic step(input logic [3:0] ev);
        {bus.start, bus.miss, bus.bomb, bus.bonus} = ev;
        @(posedge clock);
        #1;
        {bus.start, bus.miss, bus.bomb, bus.bonus} = 4'b0;
    endtask
    task automatic wait_hit();
        int n = 0;
        while (bus.invuln && n < 10) begin
            step(4'b0000);
            n++;
        end
        checks++;
        if (bus.invuln !== 1'b0) begin
            errors++;
            $display("FAIL hit_timeout: invuln=%b required 0 within 10 cycles", bus.invuln);
        end
    endtask
    task automatic test_reset();
        {bus.start, bus.miss, bus.bomb, bus.bonus} = 4'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL reset: got %b required %b", obs, 6'b0); end
        resetn = 1'b1;
        step(4'b0111);
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL idle_ignore: got %b required %b", obs, 6'b0); end
    endtask
    task automatic test_start();
        step(4'b1000);
        checks++;
        if (obs !== {2'd3, 4'b1000}) begin errors++; $display("FAIL start: got %b required %b", obs, {2'd3, 4'b1000}); end
    endtask
    task automatic test_miss_hit();
        step(4'b0100);
        checks++;
        if (obs !== {2'd2, 4'b1110}) begin errors++; $display("FAIL miss: got %b required %b", obs, {2'd2, 4'b1110}); end
        for (int i = 0; i < 3; i++) begin
            step(4'b0100);
            checks++;
            if (obs !== {2'd2, 4'b1100}) begin errors++; $display("FAIL hit_ignore_%0d: got %b required %b", i, obs, {2'd2, 4'b1100}); end
        end
        step(4'b0000);
        checks++;
        if (obs !== {2'd2, 4'b1000}) begin errors++; $display("FAIL hit_end: got %b required %b", obs, {2'd2, 4'b1000}); end
    endtask
    task automatic test_bonus();
        exp_lives = BEN ? 2'd3 : 2'd2;
        step(4'b0001);
        checks++;
        if (obs !== {exp_lives, 4'b1000}) begin errors++; $display("FAIL bonus: got %b required %b", obs, {exp_lives, 4'b1000}); end
        step(4'b0001);
        checks++;
        if (obs !== {exp_lives, 4'b1000}) begin errors++; $display("FAIL bonus_sat: got %b required %b", obs, {exp_lives, 4'b1000}); end
        exp_lives = exp_lives - 2'd1;
        step(4'b0101);
        checks++;
        if (obs !== {exp_lives, 4'b1110}) begin errors++; $display("FAIL miss_bonus: got %b required %b", obs, {exp_lives, 4'b1110}); end
        exp_lives = BEN ? exp_lives + 2'd1 : exp_lives;
        step(4'b0001);
        checks++;
        if (obs !== {exp_lives, 4'b1100}) begin errors++; $display("FAIL hit_bonus: got %b required %b", obs, {exp_lives, 4'b1100}); end
        wait_hit();
    endtask
    task automatic test_bomb_over();
        while (exp_lives > 2'd1) begin
            exp_lives = exp_lives - 2'd1;
            step(4'b0100);
            checks++;
            if (obs !== {exp_lives, 4'b1110}) begin errors++; $display("FAIL drain: got %b required %b", obs, {exp_lives, 4'b1110}); end
            wait_hit();
        end
        step(4'b0010);
        checks++;
        if (obs !== {2'd0, 4'b0011}) begin errors++; $display("FAIL bomb_over: got %b required %b", obs, {2'd0, 4'b0011}); end
        step(4'b0111);
        checks++;
        if (obs !== {2'd0, 4'b0001}) begin errors++; $display("FAIL over_ignore: got %b required %b", obs, {2'd0, 4'b0001}); end
        step(4'b1000);
        checks++;
        if (obs !== {2'd3, 4'b1000}) begin errors++; $display("FAIL over_restart: got %b required %b", obs, {2'd3, 4'b1000}); end
    endtask
    task automatic test_back_to_back();
        step(4'b0110);
        checks++;
        if (obs !== {2'd2, 4'b1110}) begin errors++; $display("FAIL bomb_miss: got %b required %b", obs, {2'd2, 4'b1110}); end
        step(4'b1000);
        checks++;
        if (obs !== {2'd2, 4'b1100}) begin errors++; $display("FAIL lost_pulse: got %b required %b", obs, {2'd2, 4'b1100}); end
    endtask
    task automatic test_reset_mid_hit();
        resetn = 1'b0;
        #2;
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL async_reset: got %b required %b", obs, 6'b0); end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        step(4'b1000);
        checks++;
        if (obs !== {2'd3, 4'b1000}) begin errors++; $display("FAIL reset_restart: got %b required %b", obs, {2'd3, 4'b1000}); end
    endtask
    initial begin
        test_reset();
        test_start();
        test_miss_hit();
        test_bonus();
        test_bomb_over();
        test_back_to_back();
        test_reset_mid_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
